// File: rtl/stego_pkg.sv
// Shared constants and FSM encoding for the stego embed controller.
package stego_pkg;

  localparam int PIXELS_PER_WORD = 4;
  localparam int PIXELS_PER_READ = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/stego_pix_reg.sv
// Output pixel holding register; optionally overwrites each channel LSB with
// its message bit while loading (bit 2 -> R, bit 1 -> G, bit 0 -> B).
module stego_pix_reg
  import stego_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   embed,
  input  logic [2:0]             bits,
  input  logic [PIXEL_WIDTH-1:0] din_r,
  input  logic [PIXEL_WIDTH-1:0] din_g,
  input  logic [PIXEL_WIDTH-1:0] din_b,
  input  logic                   rdy,
  output logic [PIXEL_WIDTH-1:0] pix_r,
  output logic [PIXEL_WIDTH-1:0] pix_g,
  output logic [PIXEL_WIDTH-1:0] pix_b,
  output logic                   pix_vld
);

  // Channel index 2 is R so that channel gi pairs with bits[gi].
  logic [PIXELS_PER_READ-1:0][PIXEL_WIDTH-1:0] din;
  logic [PIXELS_PER_READ-1:0][PIXEL_WIDTH-1:0] chan_next;
  logic [PIXELS_PER_READ-1:0][PIXEL_WIDTH-1:0] chan_reg;

  assign din = {din_r, din_g, din_b};

  for (genvar gi = 0; gi < PIXELS_PER_READ; gi++) begin : g_chan
    assign chan_next[gi] = {din[gi][PIXEL_WIDTH-1:1], embed ? bits[gi] : din[gi][0]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      chan_reg <= '0;
      pix_vld  <= 1'b0;
    end else if (load) begin
      chan_reg <= chan_next;
      pix_vld  <= 1'b1;
    end else if (rdy) begin
      pix_vld  <= 1'b0;
    end
  end

  assign pix_r = chan_reg[2];
  assign pix_g = chan_reg[1];
  assign pix_b = chan_reg[0];

endmodule

// File: rtl/stego_embed_ctrl.sv
// Stego embed controller: feeds packed source words into an external byte FIFO
// and drains it three bytes at a time into RGB pixels carrying message bits.
module stego_embed_ctrl
  import stego_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   num_pix,
  input  logic [CNT_WIDTH-1:0]   msg_len,
  input  logic [DATA_WIDTH-1:0]  src_data,
  input  logic                   src_vld,
  output logic                   src_rdy,
  input  logic [2:0]             msg_bits,
  input  logic                   msg_vld,
  output logic                   msg_rdy,
  output logic [DATA_WIDTH-1:0]  fifo_din,
  output logic                   fifo_wr_req,
  input  logic                   fifo_wr_vld,
  output logic                   fifo_rd_req,
  input  logic                   fifo_rd_vld,
  input  logic [PIXEL_WIDTH-1:0] fifo_dout1,
  input  logic [PIXEL_WIDTH-1:0] fifo_dout2,
  input  logic [PIXEL_WIDTH-1:0] fifo_dout3,
  output logic [PIXEL_WIDTH-1:0] pix_r,
  output logic [PIXEL_WIDTH-1:0] pix_g,
  output logic [PIXEL_WIDTH-1:0] pix_b,
  output logic                   pix_vld,
  input  logic                   pix_rdy,
  output logic                   busy,
  output logic                   done
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t state_reg, state_next;

  logic [CNT_WIDTH-1:0] num_pix_reg;
  logic [CNT_WIDTH-1:0] budget_reg;   // source words still to accept
  logic [CNT_WIDTH-1:0] rd_left_reg;  // triplet reads still to issue
  logic [CNT_WIDTH-1:0] emb_cnt_reg;  // triplets still to embed
  logic [CNT_WIDTH-1:0] out_cnt_reg;
  logic                 inflight_reg;
  logic                 emb_now_reg;
  logic [2:0]           emb_bits_reg;

  logic [CNT_WIDTH-1:0] quads;
  logic [CNT_WIDTH-1:0] budget_init;
  logic [CNT_WIDTH-1:0] msg_clip;
  logic                 active;

  assign quads       = num_pix / CNT_WIDTH'(PIXELS_PER_WORD);
  assign budget_init = quads * CNT_WIDTH'(PIXELS_PER_READ);
  assign msg_clip    = (msg_len > num_pix) ? num_pix : msg_len;

  assign fifo_din    = src_data;
  assign fifo_wr_req = src_vld & src_rdy;

  always_comb begin
    state_next  = state_reg;
    active      = (state_reg == RUN) || (state_reg == DRAIN);
    // A read lands one cycle later, so the output slot must be free by then.
    fifo_rd_req = active && fifo_rd_vld && !inflight_reg && (rd_left_reg != '0) &&
                  (!pix_vld || pix_rdy) && ((emb_cnt_reg == '0) || msg_vld);
    msg_rdy     = fifo_rd_req && (emb_cnt_reg != '0);
    src_rdy     = (state_reg == RUN) && (budget_reg != '0) && fifo_wr_vld && !fifo_rd_req;
    busy        = active;
    done        = (state_reg == DONE);

    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (budget_reg == '0) state_next = DRAIN;
      DRAIN:   if (out_cnt_reg == num_pix_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      num_pix_reg  <= '0;
      budget_reg   <= '0;
      rd_left_reg  <= '0;
      emb_cnt_reg  <= '0;
      out_cnt_reg  <= '0;
      inflight_reg <= 1'b0;
      emb_now_reg  <= 1'b0;
      emb_bits_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        num_pix_reg  <= num_pix;
        budget_reg   <= budget_init;
        rd_left_reg  <= num_pix;
        emb_cnt_reg  <= msg_clip;
        out_cnt_reg  <= '0;
        inflight_reg <= 1'b0;
        emb_now_reg  <= 1'b0;
      end else begin
        if (fifo_wr_req) budget_reg <= budget_reg - CNT_ONE;
        if (fifo_rd_req) begin
          rd_left_reg <= rd_left_reg - CNT_ONE;
          if (emb_cnt_reg != '0) emb_cnt_reg <= emb_cnt_reg - CNT_ONE;
        end
        inflight_reg <= fifo_rd_req;
        emb_now_reg  <= msg_rdy;
        emb_bits_reg <= msg_bits;
        if (pix_vld && pix_rdy) out_cnt_reg <= out_cnt_reg + CNT_ONE;
      end
    end
  end

  stego_pix_reg #(
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_pix_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (inflight_reg),
    .embed  (emb_now_reg),
    .bits   (emb_bits_reg),
    .din_r  (fifo_dout1),
    .din_g  (fifo_dout2),
    .din_b  (fifo_dout3),
    .rdy    (pix_rdy),
    .pix_r  (pix_r),
    .pix_g  (pix_g),
    .pix_b  (pix_b),
    .pix_vld(pix_vld)
  );

endmodule

// File: tb/tb_stego_embed_ctrl.sv
// Randomized bench for stego_embed_ctrl with a byte-FIFO model and a
// stream-level reference for the expected pixel sequence.
module tb_stego_embed_ctrl;

  localparam int DW = 32;
  localparam int PW = 8;
  localparam int CW = 20;
  localparam int FIFO_CAP = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start;
  logic [CW-1:0] num_pix, msg_len;
  logic [DW-1:0] src_data, fifo_din;
  logic          src_vld, src_rdy;
  logic [2:0]    msg_bits;
  logic          msg_vld, msg_rdy;
  logic          fifo_wr_req, fifo_wr_vld, fifo_rd_req, fifo_rd_vld;
  logic [PW-1:0] fifo_dout1, fifo_dout2, fifo_dout3;
  logic [PW-1:0] pix_r, pix_g, pix_b;
  logic          pix_vld, pix_rdy, busy, done;

  stego_embed_ctrl #(.DATA_WIDTH(DW), .PIXEL_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_pix(num_pix), .msg_len(msg_len),
    .src_data(src_data), .src_vld(src_vld), .src_rdy(src_rdy),
    .msg_bits(msg_bits), .msg_vld(msg_vld), .msg_rdy(msg_rdy),
    .fifo_din(fifo_din), .fifo_wr_req(fifo_wr_req), .fifo_wr_vld(fifo_wr_vld),
    .fifo_rd_req(fifo_rd_req), .fifo_rd_vld(fifo_rd_vld),
    .fifo_dout1(fifo_dout1), .fifo_dout2(fifo_dout2), .fifo_dout3(fifo_dout3),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
    .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] fq[$];
  logic [PW-1:0] rd_hold[3];
  bit            rd_pend;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // FIFO model outputs change only just after a clock edge.
  task automatic drive_fifo();
    if (rd_pend) begin
      fifo_dout1 = rd_hold[0];
      fifo_dout2 = rd_hold[1];
      fifo_dout3 = rd_hold[2];
      rd_pend = 1'b0;
    end
    fifo_rd_vld = (fq.size() >= 3);
    fifo_wr_vld = (fq.size() <= FIFO_CAP - 4);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({pix_r, pix_g, pix_b, pix_vld, src_rdy, msg_rdy,
                fifo_wr_req, fifo_rd_req, busy, done});
  endfunction

  task automatic run_frame(input int np, input int ml, input bit rnd,
                           input int stall_at, input int mstall_at, input int abort_at);
    logic [DW-1:0] words[$];
    logic [2:0]    msgs[$];
    logic [PW-1:0] bytes_q[$];
    logic [PW-1:0] er, eg, eb, last_r, last_g, last_b;
    logic [2:0]    m;
    int nw, emb, widx, midx, oidx, dones, cyc;
    int viol_x, viol_src, viol_stab, viol_rd, viol_msg;
    bit held, finished;

    nw = (np / 4) * 3;
    emb = (ml > np) ? np : ml;
    widx = 0; midx = 0; oidx = 0; dones = 0;
    viol_x = 0; viol_src = 0; viol_stab = 0; viol_rd = 0; viol_msg = 0;
    held = 1'b0; finished = 1'b0;
    last_r = '0; last_g = '0; last_b = '0;
    for (int i = 0; i < nw; i++) words.push_back($urandom);
    for (int i = 0; i < np; i++) msgs.push_back(3'($urandom_range(0, 7)));
    foreach (words[i]) for (int b = 0; b < 4; b++) bytes_q.push_back(words[i][8*b +: 8]);

    @(posedge clk); #1;
    drive_fifo();
    num_pix = CW'(np); msg_len = CW'(ml); start = 1'b1;
    src_vld = 1'b0; msg_vld = 1'b0; pix_rdy = 1'b1;

    for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(posedge clk); #1;
      if (cyc == abort_at) begin
        rst = 1'b0; start = 1'b0; src_vld = 1'b0; msg_vld = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(posedge clk); #1;
          @(negedge clk);
          chk("rst_zero", out_vec(), 64'(0));
          if (done) dones++;
        end
        @(posedge clk); #1;
        rst = 1'b1; fq.delete(); rd_pend = 1'b0;
        drive_fifo();
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          if (done || busy) dones++;
          @(posedge clk); #1;
        end
        chk("abort_no_done", 64'(dones), 64'(0));
        $display("frame np=%0d ml=%0d aborted at cycle %0d", np, ml, cyc);
        return;
      end
      drive_fifo();
      start    = (cyc == 7);
      num_pix  = (cyc == 7) ? CW'(np + 4) : CW'(np);
      src_vld  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_data = (widx < nw) ? words[widx] : $urandom;
      msg_bits = (midx < np) ? msgs[midx] : 3'($urandom_range(0, 7));
      if (mstall_at >= 0 && cyc >= mstall_at && cyc < mstall_at + 8) msg_vld = 1'b0;
      else msg_vld = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 10) pix_rdy = 1'b0;
      else pix_rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;

      @(negedge clk);
      if (cyc == 0) chk("busy_run", 64'(busy), 64'(1));
      if (fifo_wr_req && fifo_rd_req) viol_x++;
      if (fifo_wr_req !== (src_vld && src_rdy)) viol_x++;
      if (fifo_din !== src_data) viol_x++;
      if (fifo_wr_req && !fifo_wr_vld) viol_x++;
      if (fifo_rd_req && !fifo_rd_vld) viol_x++;
      if (src_rdy && widx >= nw) viol_src++;
      if (held && (!pix_vld || pix_r !== last_r || pix_g !== last_g || pix_b !== last_b)) viol_stab++;
      if (pix_vld && !pix_rdy && fifo_rd_req) viol_rd++;
      if (msg_rdy && midx >= emb) viol_msg++;
      held = pix_vld && !pix_rdy;
      last_r = pix_r; last_g = pix_g; last_b = pix_b;

      if (fifo_wr_req) for (int b = 0; b < 4; b++) fq.push_back(fifo_din[8*b +: 8]);
      if (src_vld && src_rdy) widx++;
      if (fifo_rd_req && fq.size() >= 3) begin
        for (int b = 0; b < 3; b++) rd_hold[b] = fq.pop_front();
        rd_pend = 1'b1;
      end
      if (msg_vld && msg_rdy) midx++;
      if (pix_vld && pix_rdy) begin
        if (oidx < np) begin
          er = bytes_q[3*oidx]; eg = bytes_q[3*oidx+1]; eb = bytes_q[3*oidx+2];
          if (oidx < emb) begin
            m = msgs[oidx];
            er[0] = m[2]; eg[0] = m[1]; eb[0] = m[0];
          end
          chk("pix", 64'({pix_r, pix_g, pix_b}), 64'({er, eg, eb}));
        end
        oidx++;
      end
      if (done) begin
        dones++;
        finished = 1'b1;
      end
    end

    chk("timeout", 64'(finished), 64'(1));
    chk("pix_cnt", 64'(oidx), 64'(np));
    chk("words", 64'(widx), 64'(nw));
    chk("msgs", 64'(midx), 64'(emb));
    chk("done_cnt", 64'(dones), 64'(1));
    chk("fifo_empty", 64'(fq.size()), 64'(0));
    chk("wr_rd_excl", 64'(viol_x), 64'(0));
    chk("src_budget", 64'(viol_src), 64'(0));
    chk("pix_stable", 64'(viol_stab), 64'(0));
    chk("rd_in_stall", 64'(viol_rd), 64'(0));
    chk("msg_rdy", 64'(viol_msg), 64'(0));

    @(posedge clk); #1;
    drive_fifo();
    start = 1'b0; src_vld = 1'b0; msg_vld = 1'b0;
    @(negedge clk);
    chk("idle_after", 64'({busy, done}), 64'(0));
    $display("frame np=%0d ml=%0d pixels=%0d words=%0d msgs=%0d cycles=%0d",
             np, ml, oidx, widx, midx, cyc);
  endtask

  initial begin
    int np, ml;
    rst = 1'b0; start = 1'b0; num_pix = '0; msg_len = '0;
    src_data = '0; src_vld = 1'b0; msg_bits = '0; msg_vld = 1'b0;
    fifo_wr_vld = 1'b1; fifo_rd_vld = 1'b0;
    fifo_dout1 = '0; fifo_dout2 = '0; fifo_dout3 = '0;
    pix_rdy = 1'b0; rd_pend = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", out_vec(), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    run_frame(4, 4, 1'b0, -1, -1, -1);
    run_frame(8, 0, 1'b1, -1, -1, -1);
    run_frame(16, 16, 1'b0, 12, -1, -1);
    run_frame(4, 2, 1'b0, -1, 2, -1);
    run_frame(12, 20, 1'b1, -1, -1, -1);
    run_frame(16, 9, 1'b1, -1, -1, 10);
    run_frame(8, 5, 1'b1, -1, -1, -1);
    for (int f = 0; f < 4; f++) begin
      np = 4 * $urandom_range(1, 8);
      ml = $urandom_range(0, np + 4);
      run_frame(np, ml, 1'b1, -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
